// File: rtl/lift_request_latch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lift_request_latch_if : call switches / serve status / request bus    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface lift_request_latch_if;
   logic [15:0] sw;
   logic [3:0]  serve_floor;
   logic        serve_open;
   logic [15:0] req;
   logic        req_any;
   logic        req_above;
   logic        req_below;
   logic [4:0]  req_count;

   modport master (
      output sw, serve_floor, serve_open,
      input  req, req_any, req_above, req_below, req_count
   );

   modport slave (
      input  sw, serve_floor, serve_open,
      output req, req_any, req_above, req_below, req_count
   );
endinterface
`default_nettype wire

// File: rtl/lift_request_latch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lift_request_latch : debounced floor-call switches -> sticky requests |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module lift_request_latch #(
   parameter int FLOORS     = 16,
   parameter int SAMPLE_DIV = 20_000_000,
   parameter int DEB_LEN    = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   lift_request_latch_if.slave  bus
);

   localparam int              CNT_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [15:0]     C_ACTIVE   = 16'((17'd1 << FLOORS) - 17'd1);

   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic                         tick;
   logic [15:0]                  meta_q, sw_s_q;
   logic [15:0][DEB_LEN-1:0]     hist_q, hist_d;
   logic [15:0]                  deb_q, deb_d;
   logic [15:0]                  deb_dly_q;
   logic [15:0]                  req_q, req_d;
   logic [15:0]                  press;
   logic [15:0]                  clr;

   always_comb begin
      tick  = (cnt_q == C_CNT_LAST);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   // Debounced level only moves once the whole history agrees.
   always_comb begin
      hist_d = hist_q;
      deb_d  = deb_q;
      if (tick) begin
         for (int i = 0; i < 16; i++) begin
            hist_d[i] = {hist_q[i][DEB_LEN-2:0], sw_s_q[i]};
            if (&hist_d[i])
               deb_d[i] = 1'b1;
            else if (~|hist_d[i])
               deb_d[i] = 1'b0;
         end
      end
   end

   // Clear is applied after set so a press at an open door is absorbed.
   always_comb begin
      press = deb_q & ~deb_dly_q;
      clr   = '0;
      if (bus.serve_open && (int'(bus.serve_floor) < FLOORS))
         clr[bus.serve_floor] = 1'b1;
      req_d = (req_q | press) & ~clr;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         meta_q    <= '0;
         sw_s_q    <= '0;
         hist_q    <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         req_q     <= '0;
      end else begin
         cnt_q     <= cnt_d;
         meta_q    <= bus.sw & C_ACTIVE;
         sw_s_q    <= meta_q;
         hist_q    <= hist_d;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         req_q     <= req_d;
      end
   end

   always_comb begin
      bus.req       = req_q;
      bus.req_any   = |req_q;
      bus.req_above = 1'b0;
      bus.req_below = 1'b0;
      bus.req_count = '0;
      for (int i = 0; i < 16; i++) begin
         if (req_q[i]) begin
            bus.req_count = bus.req_count + 5'd1;
            if (i > int'(bus.serve_floor))
               bus.req_above = 1'b1;
            if (i < int'(bus.serve_floor))
               bus.req_below = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lift_request_latch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lift_request_latch : directed + randomized bench with ref model    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_lift_request_latch;
   localparam int FL = 16;
   localparam int SD = 4;
   localparam int DL = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lift_request_latch_if bus ();

   lift_request_latch #(.FLOORS(FL), .SAMPLE_DIV(SD), .DEB_LEN(DL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: run-length count of equal slow samples per channel.
   logic [15:0] m_req, m_p1, m_p2, m_press;
   logic        m_last [16];
   logic        m_deb  [16];
   int          m_run  [16];
   int          m_edges;

   always @(posedge clk) begin : model
      logic [15:0] nreq;
      if (!rst_n) begin
         m_req = '0; m_p1 = '0; m_p2 = '0; m_press = '0; m_edges = 0;
         for (int c = 0; c < 16; c++) begin
            m_last[c] = 1'b0; m_deb[c] = 1'b0; m_run[c] = DL;
         end
      end else begin
         m_edges++;
         nreq = m_req | m_press;
         if (bus.serve_open && int'(bus.serve_floor) < FL)
            nreq[bus.serve_floor] = 1'b0;
         m_press = '0;
         if (m_edges % SD == 0) begin
            for (int c = 0; c < 16; c++) begin
               if (m_p2[c] == m_last[c]) begin
                  if (m_run[c] < DL) m_run[c]++;
               end else begin
                  m_last[c] = m_p2[c];
                  m_run[c]  = 1;
               end
               if (m_run[c] >= DL && m_deb[c] != m_last[c]) begin
                  m_deb[c] = m_last[c];
                  if (m_last[c]) m_press[c] = 1'b1;
               end
            end
         end
         m_p2  = m_p1;
         m_p1  = bus.sw;
         m_req = nreq;
      end
   end

   // {any, above, below, count[4:0]} derived from a request vector and floor
   function automatic logic [7:0] summ(input logic [15:0] r, input logic [3:0] f);
      logic a, b; int n;
      a = 1'b0; b = 1'b0; n = 0;
      for (int i = 0; i < 16; i++)
         if (r[i]) begin
            n++;
            if (i > int'(f)) a = 1'b1;
            if (i < int'(f)) b = 1'b1;
         end
      return {|r, a, b, 5'(n)};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; bus.sw = '0; bus.serve_open = 1'b0; bus.serve_floor = '0;
      cyc(2);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      int n;
      bit seen;
      @(negedge clk);
      rst_n = 1'b0; bus.sw = 16'hFFFF; bus.serve_open = 1'b0; bus.serve_floor = 4'd0;
      cyc(3);
      checks++;
      if (bus.req !== 16'h0000 || bus.req_count !== 5'd0) begin
         errors++;
         $display("FAIL reset_req got req=%h count=%0d exp req=0000 count=0", bus.req, bus.req_count);
      end
      checks++;
      if ({bus.req_any, bus.req_above, bus.req_below} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got %b exp 000", {bus.req_any, bus.req_above, bus.req_below});
      end
      bus.sw = 16'h0001;
      rst_n  = 1'b1;
      n = 0; seen = 0;
      while (n < 30 && !seen) begin
         @(negedge clk);
         n++;
         if (bus.req[0]) seen = 1;
      end
      checks++;
      if (!seen || n < 11 || n > 15) begin
         errors++;
         $display("FAIL press_latency got %0d cycles (seen=%0d) exp 11..15", n, seen);
      end
      checks++;
      if (bus.req !== 16'h0001) begin
         errors++;
         $display("FAIL press_vector got %h exp 0001", bus.req);
      end
   endtask

   task automatic test_glitch();
      do_reset();
      cyc(2);
      bus.sw[5] = 1'b1;
      cyc(6);
      bus.sw[5] = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         checks++;
         if (bus.req[5] !== 1'b0) begin
            errors++;
            $display("FAIL glitch cycle %0d got req[5]=%b exp 0", k, bus.req[5]);
         end
      end
   endtask

   task automatic test_serve();
      do_reset();
      bus.serve_floor = 4'd3;
      bus.sw = 16'h0208;
      cyc(20);
      bus.sw = 16'h0000;
      cyc(2);
      checks++;
      if ({bus.req, bus.req_above, bus.req_below, bus.req_count} !== {16'h0208, 1'b1, 1'b0, 5'd2}) begin
         errors++;
         $display("FAIL serve_set got req=%h above=%b below=%b count=%0d exp 0208 1 0 2",
                  bus.req, bus.req_above, bus.req_below, bus.req_count);
      end
      bus.serve_open = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.req !== 16'h0200 || bus.req_count !== 5'd1) begin
         errors++;
         $display("FAIL serve_clear got req=%h count=%0d exp 0200 1", bus.req, bus.req_count);
      end
      bus.serve_open = 1'b0;
   endtask

   task automatic test_clear_wins();
      do_reset();
      bus.serve_floor = 4'd7;
      bus.serve_open  = 1'b1;
      bus.sw[7] = 1'b1;
      for (int k = 0; k < 60; k++) begin
         if (k == 30) bus.serve_open = 1'b0;
         @(negedge clk);
         checks++;
         if (bus.req[7] !== 1'b0) begin
            errors++;
            $display("FAIL clear_wins cycle %0d got req[7]=%b exp 0", k, bus.req[7]);
         end
      end
      bus.sw[7] = 1'b0;
      cyc(30);
      bus.sw[7] = 1'b1;
      cyc(20);
      checks++;
      if (bus.req[7] !== 1'b1) begin
         errors++;
         $display("FAIL repress got req[7]=%b exp 1", bus.req[7]);
      end
      bus.sw[7] = 1'b0;
   endtask

   task automatic test_summary();
      do_reset();
      bus.sw = 16'h8001;
      cyc(20);
      bus.sw = 16'h0000;
      bus.serve_floor = 4'd0;
      #1;
      checks++;
      if ({bus.req, bus.req_above, bus.req_below} !== {16'h8001, 2'b10}) begin
         errors++;
         $display("FAIL summary_f0 got req=%h above=%b below=%b exp 8001 1 0", bus.req, bus.req_above, bus.req_below);
      end
      bus.serve_floor = 4'd15;
      #1;
      checks++;
      if ({bus.req_above, bus.req_below} !== 2'b01) begin
         errors++;
         $display("FAIL summary_f15 got above=%b below=%b exp 0 1", bus.req_above, bus.req_below);
      end
      bus.serve_floor = 4'd8;
      #1;
      checks++;
      if ({bus.req_above, bus.req_below, bus.req_count} !== {2'b11, 5'd2}) begin
         errors++;
         $display("FAIL summary_f8 got above=%b below=%b count=%0d exp 1 1 2",
                  bus.req_above, bus.req_below, bus.req_count);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      bus.serve_floor = 4'd0;
      bus.sw = 16'h0F0F;
      cyc(20);
      checks++;
      if (bus.req !== 16'h0F0F) begin
         errors++;
         $display("FAIL midrst_pre got %h exp 0F0F", bus.req);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.req, bus.req_any, bus.req_above, bus.req_below, bus.req_count} !== 24'h0) begin
         errors++;
         $display("FAIL midrst_clear got req=%h any=%b count=%0d exp all 0", bus.req, bus.req_any, bus.req_count);
      end
      rst_n = 1'b1;
      cyc(20);
      checks++;
      if (bus.req !== 16'h0F0F) begin
         errors++;
         $display("FAIL midrst_relatch got %h exp 0F0F", bus.req);
      end
      bus.sw = '0;
   endtask

   task automatic test_random();
      int k;
      logic [7:0] exp_s;
      do_reset();
      for (int cy = 0; cy < 3000; cy++) begin
         @(negedge clk);
         checks++;
         if (bus.req !== m_req) begin
            errors++;
            $display("FAIL rand_req cycle %0d got %h exp %h", cy, bus.req, m_req);
         end
         exp_s = summ(m_req, bus.serve_floor);
         checks++;
         if ({bus.req_any, bus.req_above, bus.req_below, bus.req_count} !== exp_s) begin
            errors++;
            $display("FAIL rand_summary cycle %0d got %b exp %b", cy,
                     {bus.req_any, bus.req_above, bus.req_below, bus.req_count}, exp_s);
         end
         if ($urandom_range(0, 9) == 0) begin
            k = $urandom_range(0, 15);
            bus.sw[k] = ~bus.sw[k];
         end
         if ($urandom_range(0, 15) == 0) bus.serve_floor = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0)  bus.serve_open  = ($urandom_range(0, 2) == 0);
      end
   endtask

   initial begin
      bus.sw = '0; bus.serve_floor = '0; bus.serve_open = 1'b0;
      test_reset();
      test_glitch();
      test_serve();
      test_clear_wins();
      test_summary();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/lift_request_latch.md
# lift_request_latch

Upstream stage of the lift controller: conditions the 16 raw floor-call switches and holds each call as a pending request until the lift serves that floor. Each switch is synchronised, sampled at a slow rate, debounced and edge-detected; the resulting press sets a sticky request bit. A request bit is cleared when the controller reports the door open at that floor. Outputs are the request vector the controller consumes, plus summary flags (any/above/below/count) relative to the current floor.

## Interface
- FLOORS, 16, number of floor channels (1..16); channels at index ≥ FLOORS are tied inactive
- SAMPLE_DIV, 20_000_000, clk cycles per debounce sample (200 ms at 100 MHz)
- DEB_LEN, 3, consecutive equal samples required to change a debounced level (≥2)
- clk  input  1  single system clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- sw  input  16  raw asynchronous call switches, bit i = floor i
- serve_floor  input  4  current floor from the controller (its lift_num)
- serve_open  input  1  door-open indication from the controller (its lift_open)
- req  output  16  registered pending-request vector to the controller
- req_any  output  1  OR of req
- req_above  output  1  any req bit at index > serve_floor
- req_below  output  1  any req bit at index < serve_floor
- req_count  output  5  population count of req (0..16)

## Operation
- Sync: each sw bit passes through a 2-FF synchroniser (sw_s).
- Sample tick: free-running counter 0..SAMPLE_DIV-1; tick asserted for one cycle when counter = SAMPLE_DIV-1, then counter wraps to 0.
- Debounce, per channel: on tick, shift sw_s into a DEB_LEN-bit history. If the post-shift history is all 1s, deb becomes 1; all 0s, deb becomes 0; otherwise deb holds.
- Edge detect: press_i = deb_i & ~deb_d_i, where deb_d is deb delayed one clk; press is a one-cycle pulse.
- Request set: press_i sets req[i].
- Request clear: when serve_open = 1 and serve_floor = i, req[i] is cleared every cycle that condition holds.
- Simultaneous set and clear on the same bit: clear wins. A held switch does not re-request; it must be released (deb → 0) and pressed again.
- Press at the current floor while the door is open is absorbed (cleared immediately); while the door is closed it is latched.
- serve_floor ≥ FLOORS: no clear occurs; req_above = 0; req_below reflects all bits.
- Summary outputs are combinational from the req register and serve_floor: req_above/req_below use strict comparison; bit serve_floor itself contributes to neither. req_count is the popcount of req.

## Timing
- Reset (rst_n = 0 at a clk edge): req = 0, req_any = 0, req_above = 0, req_below = 0, req_count = 0; synchronisers, histories, deb, deb_d and the tick counter are all cleared to 0.
- Reset mid-operation discards all pending requests and debounce state. After release, a switch already held high is treated as a new press once debounced.
- Press latency, from sw rising to req[i] = 1: synchroniser 2 cycles, plus DEB_LEN ticks, plus 1 cycle edge detect/set.
  - Maximum: 2 + DEB_LEN·SAMPLE_DIV + 1 cycles.
  - Minimum: 2 + (DEB_LEN-1)·SAMPLE_DIV + 1 cycles.
- Glitch rejection: a pulse shorter than (DEB_LEN-1)·SAMPLE_DIV cycles never sets a request.
- Clear latency: req[i] drops at the first clk edge where serve_open = 1 and serve_floor = i are sampled; the summary outputs follow in the same cycle.
- No handshake: req is level-valid every cycle; the controller may sample it on any clock domain edge derived from clk.

## Test plan
(Sim parameters: SAMPLE_DIV = 4, DEB_LEN = 3.)
- Reset: drive sw = 16'hFFFF during rst_n = 0 → req = 0, req_count = 0. Release and hold sw = 16'h0001 → req = 16'h0001 within 15 cycles and not before 11.
- Glitch: sw[5] high for 6 cycles, then low → req[5] stays 0 for 40 cycles.
- Serve/clear:
  - Set req bits 3 and 9, with serve_floor = 3 and serve_open = 0 → req_above = 1, req_below = 0, req_count = 2.
  - Assert serve_open → req = 16'h0200 next edge, req_count = 1.
- Clear-wins: serve_floor = 7, serve_open = 1, press sw[7] → req[7] never rises. Then drop serve_open while sw[7] stays held → req[7] stays 0. Release and press again → req[7] = 1.
- Summary: req = 16'h8001 with serve_floor = 0 → above = 1, below = 0. With serve_floor = 15 → above = 0, below = 1. With serve_floor = 8 → both 1, count = 2.
- Mid-run reset: with req = 16'h0F0F, pulse rst_n low for 1 cycle → all outputs 0 next edge. Switches still held re-latch after debounce.
